// File: rtl/dmem_pkg.sv
// Shared types and widths for the data-memory stage and neighbouring pipeline stages.
package dmem_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Everything captured from the pipeline at acceptance, used until the access retires.
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  rd2;
        logic              reg_wr;
        logic              wb;
        logic              is_read;
        logic              addr_err;
    } req_t;

    // True when the word address has bits set above the implemented array depth.
    function automatic logic addr_out_of_range(input logic [DATA_W-1:0] addr, input int aw);
        return (addr >> aw) != '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data memory: synchronous write, registered read with an optional forced-zero result.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic              rd_zero,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // NOTE: the storage array has no reset; resetting it would turn it into a huge flop bank.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = rd_zero ? '0 : mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY+1 cycles per access,
// then presents read data and the writeback sideband for exactly one cycle.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRIn,
    input  logic              MemWIn,
    input  logic [15:0]       AddrIn,
    input  logic [15:0]       DataIn,
    input  logic [2:0]        Rd2In,
    input  logic              RegWrIn,
    input  logic              WBIn,
    output logic              Stall,
    output logic [15:0]       DataOut,
    output logic              DataValid,
    output logic [2:0]        Rd2Out,
    output logic              RegWrOut,
    output logic              WBOut,
    output logic              AddrErr
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    req_t               req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic               data_valid_q, data_valid_d;
    logic [REG_W-1:0]   rd2_out_q, rd2_out_d;
    logic               reg_wr_out_q, reg_wr_out_d;
    logic               wb_out_q, wb_out_d;
    logic               addr_err_q, addr_err_d;

    logic               stall;
    logic               commit;
    logic               conflict;
    logic [DATA_W-1:0]  rdata;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        addr_d   = addr_q;
        stall    = 1'b0;
        commit   = 1'b0;
        conflict = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (MemRIn ^ MemWIn) begin
                    stall            = 1'b1;
                    addr_d           = AddrIn[ADDR_W-1:0];
                    req_d.data       = DataIn;
                    req_d.rd2        = Rd2In;
                    req_d.reg_wr     = RegWrIn;
                    req_d.wb         = WBIn;
                    req_d.is_read    = MemRIn;
                    req_d.addr_err   = addr_out_of_range(AddrIn, ADDR_W);
                    cnt_d            = CNT_W'(LATENCY - 1);
                    state_d          = ST_BUSY;
                end else if (MemRIn && MemWIn) begin
                    conflict = 1'b1;
                end
            end
            ST_BUSY: begin
                stall = 1'b1;
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            // Inputs seen here belong to the request just completing and are never re-accepted.
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Result registers load on the commit edge, so they are live exactly during DONE.
    always_comb begin
        data_valid_d = commit && req_q.is_read;
        rd2_out_d    = commit ? req_q.rd2 : '0;
        reg_wr_out_d = commit && req_q.reg_wr;
        wb_out_d     = commit && req_q.wb;
        addr_err_d   = (commit && req_q.addr_err) || conflict;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            req_q        <= '0;
            addr_q       <= '0;
            data_valid_q <= 1'b0;
            rd2_out_q    <= '0;
            reg_wr_out_q <= 1'b0;
            wb_out_q     <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
            data_valid_q <= data_valid_d;
            rd2_out_q    <= rd2_out_d;
            reg_wr_out_q <= reg_wr_out_d;
            wb_out_q     <= wb_out_d;
            addr_err_q   <= addr_err_d;
        end
    end

    dmem_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (commit && !req_q.is_read && !req_q.addr_err),
        .re      (commit && req_q.is_read),
        .rd_zero (req_q.addr_err),
        .addr    (addr_q),
        .wdata   (req_q.data),
        .rdata   (rdata)
    );

    assign Stall     = stall;
    assign DataOut   = rdata;
    assign DataValid = data_valid_q;
    assign Rd2Out    = rd2_out_q;
    assign RegWrOut  = reg_wr_out_q;
    assign WBOut     = wb_out_q;
    assign AddrErr   = addr_err_q;

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width (2^ADDR_W x 16-bit words).
REQ-002 Parameter LATENCY, default 2, range 1..7, wait cycles before a request completes.
REQ-003 clk  input  1  sole clock, all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 MemRIn  input  1  read request from the execute/memory stage.
REQ-006 MemWIn  input  1  write request from the execute/memory stage.
REQ-007 AddrIn  input  16  word address (ALU result).
REQ-008 DataIn  input  16  write data (Bus2 value).
REQ-009 Rd2In / RegWrIn / WBIn  input  3/1/1  destination register, write-enable and writeback-select sideband.
REQ-010 Stall  output  1  hold request; pipeline registers upstream freeze while high.
REQ-011 DataOut  output  16  read data, registered.
REQ-012 DataValid  output  1  one-cycle pulse, DataOut valid.
REQ-013 Rd2Out / RegWrOut / WBOut  output  3/1/1  sideband captured at acceptance, registered.
REQ-014 AddrErr  output  1  one-cycle pulse, illegal address or conflicting request.

Function
REQ-015 FSM states: IDLE, BUSY, DONE; 3-bit down-counter cnt.
REQ-016 A valid request is exactly one of MemRIn, MemWIn high in IDLE.
REQ-017 IDLE + valid request: Stall=1 combinationally, latch address, data and sideband, load cnt=LATENCY-1, go to BUSY.
REQ-018 BUSY: Stall=1, decrement cnt; at cnt==0 commit the access and go to DONE.
REQ-019 Commit, read: DataOut <= mem[AddrIn[ADDR_W-1:0]] (latched address).
REQ-020 Commit, write: mem[latched address] <= latched data.
REQ-021 DONE: Stall=0; DataValid=1 for reads only; Rd2Out/RegWrOut/WBOut present the latched sideband; unconditionally go to IDLE.
REQ-022 Stall is high for exactly LATENCY+1 consecutive cycles per request, and DataValid follows in the next cycle.
REQ-023 The request still present during DONE is the completing one and SHALL NOT be re-accepted.
REQ-024 A request present in the first IDLE cycle after DONE is accepted (back-to-back).
REQ-025 AddrIn[15:ADDR_W] nonzero: full latency, AddrErr pulses in DONE, reads return 0x0000 with DataValid=1, writes are dropped.
REQ-026 MemRIn and MemWIn both high in IDLE: not accepted, Stall=0, AddrErr pulses the next cycle, memory unchanged.
REQ-027 Input changes while in BUSY are ignored, because latched values are used.
REQ-028 Outside DONE, DataValid=0, RegWrOut=0 and AddrErr=0 (except REQ-026).

Reset
REQ-029 rst_n low: state=IDLE, cnt=0, DataOut=0, DataValid=0, Rd2Out=0, RegWrOut=0, WBOut=0, AddrErr=0, Stall=0.
REQ-030 Reset during BUSY aborts the request; an uncommitted write is never performed.
REQ-031 Memory array contents are not reset.

Structure
REQ-032 A shared package holds the state enumeration, the 16-bit data width and the 3-bit register-index width, for reuse by pipeline stages.
REQ-033 The storage array is one sub-module, dmem_array (sync write, registered read, one port), and the FSM stays in dmem_responder.

Verification (LATENCY=2, ADDR_W=8)
REQ-034 Write 0xBEEF to 0x0012 and hold until Stall falls -> Stall high 3 cycles; a later read of 0x0012 gives DataOut=0xBEEF with DataValid pulse.
REQ-035 Read 0x0005 with Rd2In=3, RegWrIn=1 -> DataValid in 4th cycle, Rd2Out=3, RegWrOut=1 that cycle only.
REQ-036 Back-to-back reads 0x0001 then 0x0002 -> two DataValid pulses 4 cycles apart; no extra acceptance during DONE.
REQ-037 Read 0x0100 -> AddrErr pulse, DataOut=0x0000; write 0x0100 then read 0x0000 -> mem[0] unchanged.
REQ-038 MemRIn=MemWIn=1 -> Stall=0, AddrErr pulse next cycle, no state change.
REQ-039 Write 0x1234 to 0x0020, assert rst_n low in BUSY -> all outputs 0, IDLE; a later read of 0x0020 returns the prior value.
